mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency unified memory between two requesters: instruction fetch (IF, read-only) and the pipeline MEM stage (read/write).
- Sits between the pipeline and the external memory model.
- Serialises accesses through an FSM, tracks starvation and watchdogs each access.
- Produces a pipeline-wide stall while any requested access is outstanding.

---
 rtl/mem_port_arbiter_pkg.sv | 10 +
 rtl/mem_port_arbiter_arb_priority_sel.sv | 21 ++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM states, owner encoding and default widths.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC, RESP} state_e;
    typedef enum logic {OWN_IF, OWN_MEM} owner_e;

endpackage

// File: rtl/mem_port_arbiter_arb_priority_sel.sv
// arb_priority_sel: MEM beats IF unless IF has lost MAX_STARVE times in a row.
module arb_priority_sel
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_W   = 3,
    parameter int MAX_STARVE = 4
) (
    input  logic                if_req_i,
    input  logic                mem_req_i,
    input  logic [STARVE_W-1:0] starve_cnt_i,
    output logic                valid_o,
    output owner_e              owner_o
);

    logic starved;

    assign starved = if_req_i && (starve_cnt_i == STARVE_W'(MAX_STARVE));
    assign valid_o = if_req_i | mem_req_i;
    assign owner_o = (mem_req_i && !starved) ? OWN_MEM : OWN_IF;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF and MEM accesses onto one variable-latency
// memory port with starvation control, an access watchdog and pipeline stall.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int TIMEOUT    = 64,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ready_o,
    output logic              ext_req_o,
    output logic              ext_wr_o,
    output logic [ADDR_W-1:0] ext_addr_o,
    output logic [DATA_W-1:0] ext_wdata_o,
    input  logic              ext_ack_i,
    input  logic [DATA_W-1:0] ext_rdata_i,
    output logic              stall_o,
    output logic              err_o
);

    localparam int WAIT_W   = $clog2(TIMEOUT + 1);
    localparam int STARVE_W = $clog2(MAX_STARVE + 1);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d, win_owner;
    logic                win_valid, mem_req, timeout;
    logic                ext_wr_q, ext_wr_d, err_q, err_d;
    logic [ADDR_W-1:0]   ext_addr_q, ext_addr_d;
    logic [DATA_W-1:0]   ext_wdata_q, ext_wdata_d;
    logic [DATA_W-1:0]   if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

    assign mem_req = mem_rd_i | mem_wr_i;
    assign timeout = wait_cnt_q == WAIT_W'(TIMEOUT - 1);

    arb_priority_sel #(
        .STARVE_W  (STARVE_W),
        .MAX_STARVE(MAX_STARVE)
    ) u_sel (
        .if_req_i    (if_req_i),
        .mem_req_i   (mem_req),
        .starve_cnt_i(starve_cnt_q),
        .valid_o     (win_valid),
        .owner_o     (win_owner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        ext_wr_d     = ext_wr_q;
        ext_addr_d   = ext_addr_q;
        ext_wdata_d  = ext_wdata_q;
        if_data_d    = if_data_q;
        mem_rdata_d  = mem_rdata_q;
        wait_cnt_d   = wait_cnt_q;
        starve_cnt_d = starve_cnt_q;
        err_d        = err_q;
        case (state_q)
            IDLE: if (start_i && win_valid) begin
                state_d      = (win_owner == OWN_MEM) ? MEM_ACC : IF_ACC;
                owner_d      = win_owner;
                ext_wr_d     = (win_owner == OWN_MEM) && mem_wr_i;
                ext_addr_d   = (win_owner == OWN_MEM) ? mem_addr_i : if_addr_i;
                ext_wdata_d  = (win_owner == OWN_MEM) ? mem_wdata_i : '0;
                starve_cnt_d = (win_owner == OWN_IF) ? '0 :
                               if_req_i ? starve_cnt_q + STARVE_W'(1) : starve_cnt_q;
            end
            IF_ACC, MEM_ACC: begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                if (ext_ack_i || timeout) begin
                    state_d = RESP;
                    err_d   = err_q | ~ext_ack_i;
                    // acked writes keep the old read data; a timeout always returns 0
                    if (!(ext_ack_i && ext_wr_q)) begin
                        if (owner_q == OWN_IF) if_data_d = ext_ack_i ? ext_rdata_i : '0;
                        else mem_rdata_d = ext_ack_i ? ext_rdata_i : '0;
                    end
                end
            end
            RESP: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            ext_wr_q     <= 1'b0;
            ext_addr_q   <= '0;
            ext_wdata_q  <= '0;
            if_data_q    <= '0;
            mem_rdata_q  <= '0;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            ext_wr_q     <= ext_wr_d;
            ext_addr_q   <= ext_addr_d;
            ext_wdata_q  <= ext_wdata_d;
            if_data_q    <= if_data_d;
            mem_rdata_q  <= mem_rdata_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            err_q        <= err_d;
        end
    end

    assign ext_req_o   = (state_q == IF_ACC) || (state_q == MEM_ACC);
    assign ext_wr_o    = ext_wr_q;
    assign ext_addr_o  = ext_addr_q;
    assign ext_wdata_o = ext_wdata_q;
    assign if_data_o   = if_data_q;
    assign mem_rdata_o = mem_rdata_q;
    assign if_ready_o  = (state_q == RESP) && (owner_q == OWN_IF);
    assign mem_ready_o = (state_q == RESP) && (owner_q == OWN_MEM);
    assign err_o       = err_q;
    // reset forces every output low, including this combinational one
    assign stall_o     = ~rst_i & ((if_req_i & ~if_ready_o) | (mem_req & ~mem_ready_o));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenario tests for mem_port_arbiter.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b1;
    logic        if_req_i = 1'b0, mem_rd_i = 1'b0, mem_wr_i = 1'b0, ext_ack_i = 1'b0;
    logic [31:0] if_addr_i = '0, mem_addr_i = '0, mem_wdata_i = '0, ext_rdata_i = '0;
    logic [31:0] if_data_o, mem_rdata_o, ext_addr_o, ext_wdata_o;
    logic        if_ready_o, mem_ready_o, ext_req_o, ext_wr_o, stall_o, err_o;
    int          tests = 0, fails = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64), .MAX_STARVE(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ready_o(if_ready_o),
        .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o), .mem_ready_o(mem_ready_o),
        .ext_req_o(ext_req_o), .ext_wr_o(ext_wr_o), .ext_addr_o(ext_addr_o), .ext_wdata_o(ext_wdata_o),
        .ext_ack_i(ext_ack_i), .ext_rdata_i(ext_rdata_i), .stall_o(stall_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        #1;
        tests++; if ({ext_req_o, ext_wr_o, if_ready_o, mem_ready_o, stall_o, err_o} !== 6'b0) begin
            fails++; $display("FAIL reset_ctrl got %b exp 000000", {ext_req_o, ext_wr_o, if_ready_o, mem_ready_o, stall_o, err_o});
        end
        tests++; if ({if_data_o, mem_rdata_o, ext_addr_o, ext_wdata_o} !== 128'b0) begin
            fails++; $display("FAIL reset_data got %h %h %h %h exp 0", if_data_o, mem_rdata_o, ext_addr_o, ext_wdata_o);
        end
        cyc;
        rst_i = 1'b0;
    endtask

    task automatic test_if_read;
        if_req_i = 1'b1; if_addr_i = 32'h10;
        #1;
        tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL if_stall_req got %b exp 1", stall_o); end
        cyc;
        tests++; if ({ext_req_o, ext_wr_o, ext_addr_o} !== {2'b10, 32'h10}) begin
            fails++; $display("FAIL if_ext got req=%b wr=%b addr=%h exp 1 0 10", ext_req_o, ext_wr_o, ext_addr_o);
        end
        tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL if_stall_acc got %b exp 1", stall_o); end
        ext_ack_i = 1'b1; ext_rdata_i = 32'hDEADBEEF;
        cyc;
        ext_ack_i = 1'b0;
        tests++; if ({if_ready_o, mem_ready_o, stall_o, ext_req_o} !== 4'b1000) begin
            fails++; $display("FAIL if_resp got ready=%b mready=%b stall=%b req=%b exp 1 0 0 0", if_ready_o, mem_ready_o, stall_o, ext_req_o);
        end
        tests++; if (if_data_o !== 32'hDEADBEEF) begin fails++; $display("FAIL if_data got %h exp deadbeef", if_data_o); end
        if_req_i = 1'b0;
        cyc;
        ext_ack_i = 1'b1; ext_rdata_i = 32'h1111_1111;
        cyc;
        cyc;
        ext_ack_i = 1'b0;
        tests++; if ({if_ready_o, ext_req_o, if_data_o} !== {2'b00, 32'hDEADBEEF}) begin
            fails++; $display("FAIL if_hold got ready=%b req=%b data=%h exp 0 0 deadbeef", if_ready_o, ext_req_o, if_data_o);
        end
    endtask

    task automatic test_priority;
        if_req_i = 1'b1; if_addr_i = 32'h20;
        mem_wr_i = 1'b1; mem_addr_i = 32'h40; mem_wdata_i = 32'h12345678;
        cyc;
        tests++; if ({ext_req_o, ext_wr_o, ext_addr_o, ext_wdata_o} !== {2'b11, 32'h40, 32'h12345678}) begin
            fails++; $display("FAIL prio_mem_first got req=%b wr=%b addr=%h wd=%h exp 1 1 40 12345678", ext_req_o, ext_wr_o, ext_addr_o, ext_wdata_o);
        end
        ext_ack_i = 1'b1;
        cyc;
        ext_ack_i = 1'b0;
        tests++; if ({mem_ready_o, if_ready_o, stall_o} !== 3'b101) begin
            fails++; $display("FAIL prio_mem_resp got mready=%b iready=%b stall=%b exp 1 0 1", mem_ready_o, if_ready_o, stall_o);
        end
        mem_wr_i = 1'b0;
        cyc;
        cyc;
        tests++; if ({ext_req_o, ext_wr_o, ext_addr_o} !== {2'b10, 32'h20}) begin
            fails++; $display("FAIL prio_if_second got req=%b wr=%b addr=%h exp 1 0 20", ext_req_o, ext_wr_o, ext_addr_o);
        end
        ext_ack_i = 1'b1; ext_rdata_i = 32'hCAFE0001;
        cyc;
        ext_ack_i = 1'b0;
        tests++; if ({if_ready_o, if_data_o} !== {1'b1, 32'hCAFE0001}) begin
            fails++; $display("FAIL prio_if_resp got ready=%b data=%h exp 1 cafe0001", if_ready_o, if_data_o);
        end
        if_req_i = 1'b0;
        cyc;
    endtask

    task automatic test_starve;
        int k;
        if_req_i = 1'b1; if_addr_i = 32'h30;
        mem_rd_i = 1'b1; mem_addr_i = 32'h100;
        for (int g = 0; g < 5; g++) begin
            k = 0;
            while (!ext_req_o && k < 10) begin cyc; k++; end
            tests++; if (ext_addr_o !== ((g < 4) ? 32'h100 : 32'h30) || !ext_req_o) begin
                fails++; $display("FAIL starve_grant%0d got req=%b addr=%h exp 1 %h", g, ext_req_o, ext_addr_o, (g < 4) ? 32'h100 : 32'h30);
            end
            if (g == 4) begin
                tests++; if (mem_rdata_o !== 32'hA3) begin fails++; $display("FAIL starve_mdata got %h exp a3", mem_rdata_o); end
            end
            ext_ack_i = 1'b1; ext_rdata_i = 32'hA0 + 32'(g);
            cyc;
            ext_ack_i = 1'b0;
        end
        tests++; if ({if_ready_o, if_data_o} !== {1'b1, 32'hA4}) begin
            fails++; $display("FAIL starve_if_resp got ready=%b data=%h exp 1 a4", if_ready_o, if_data_o);
        end
        if_req_i = 1'b0; mem_rd_i = 1'b0;
        cyc;
    endtask

    task automatic test_timeout;
        int cnt = 0;
        tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL to_err_before got %b exp 0", err_o); end
        mem_rd_i = 1'b1; mem_addr_i = 32'h200;
        cyc;
        while (ext_req_o && cnt < 200) begin cnt++; cyc; end
        tests++; if (cnt != 64) begin fails++; $display("FAIL to_req_cycles got %0d exp 64", cnt); end
        tests++; if ({mem_ready_o, err_o, mem_rdata_o} !== {2'b11, 32'h0}) begin
            fails++; $display("FAIL to_resp got ready=%b err=%b data=%h exp 1 1 0", mem_ready_o, err_o, mem_rdata_o);
        end
        mem_rd_i = 1'b0;
        cyc;
        cyc;
        tests++; if ({err_o, mem_ready_o} !== 2'b10) begin
            fails++; $display("FAIL to_sticky got err=%b ready=%b exp 1 0", err_o, mem_ready_o);
        end
    endtask

    task automatic test_rd_wr_both;
        int pulses = 0;
        mem_rd_i = 1'b1; mem_wr_i = 1'b1; mem_addr_i = 32'h8; mem_wdata_i = 32'h55AA55AA;
        cyc;
        tests++; if ({ext_req_o, ext_wr_o, ext_addr_o, ext_wdata_o} !== {2'b11, 32'h8, 32'h55AA55AA}) begin
            fails++; $display("FAIL both_ext got req=%b wr=%b addr=%h wd=%h exp 1 1 8 55aa55aa", ext_req_o, ext_wr_o, ext_addr_o, ext_wdata_o);
        end
        ext_ack_i = 1'b1; ext_rdata_i = 32'hFFFFFFFF;
        cyc;
        ext_ack_i = 1'b0;
        pulses += int'(mem_ready_o);
        mem_rd_i = 1'b0; mem_wr_i = 1'b0;
        for (int i = 0; i < 4; i++) begin cyc; pulses += int'(mem_ready_o); end
        tests++; if (pulses != 1) begin fails++; $display("FAIL both_pulses got %0d exp 1", pulses); end
        tests++; if (mem_rdata_o !== 32'h0) begin fails++; $display("FAIL both_nocapture got %h exp 0", mem_rdata_o); end
    endtask

    task automatic test_start_gate;
        start_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h60;
        cyc; cyc; cyc;
        tests++; if ({ext_req_o, stall_o} !== 2'b01) begin
            fails++; $display("FAIL start_gate got req=%b stall=%b exp 0 1", ext_req_o, stall_o);
        end
        if_req_i = 1'b0; start_i = 1'b1;
        cyc;
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        mem_wr_i = 1'b1; mem_addr_i = 32'h300; mem_wdata_i = 32'h77;
        cyc;
        tests++; if (ext_req_o !== 1'b1) begin fails++; $display("FAIL rst_mid_pre got %b exp 1", ext_req_o); end
        #2 rst_i = 1'b1;
        #1;
        tests++; if ({ext_req_o, stall_o, err_o, ext_addr_o} !== {3'b000, 32'h0}) begin
            fails++; $display("FAIL rst_mid_async got req=%b stall=%b err=%b addr=%h exp 0 0 0 0", ext_req_o, stall_o, err_o, ext_addr_o);
        end
        cyc;
        mem_wr_i = 1'b0; rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin cyc; pulses += int'(mem_ready_o | ext_req_o); end
        tests++; if (pulses != 0) begin fails++; $display("FAIL rst_mid_quiet got %0d exp 0", pulses); end
        if_req_i = 1'b1; if_addr_i = 32'h44;
        cyc;
        tests++; if ({ext_req_o, ext_wr_o, ext_addr_o} !== {2'b10, 32'h44}) begin
            fails++; $display("FAIL rst_after_if got req=%b wr=%b addr=%h exp 1 0 44", ext_req_o, ext_wr_o, ext_addr_o);
        end
        ext_ack_i = 1'b1; ext_rdata_i = 32'h0BADF00D;
        cyc;
        ext_ack_i = 1'b0;
        tests++; if ({if_ready_o, if_data_o, err_o} !== {1'b1, 32'h0BADF00D, 1'b0}) begin
            fails++; $display("FAIL rst_after_resp got ready=%b data=%h err=%b exp 1 0badf00d 0", if_ready_o, if_data_o, err_o);
        end
        if_req_i = 1'b0;
        cyc;
    endtask

    initial begin
        test_reset;
        test_if_read;
        test_priority;
        test_starve;
        test_timeout;
        test_rd_wr_both;
        test_start_gate;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
